// File: rtl/acsp_uart_pkg.sv
// Definitions shared by the ACSP UART transmitter and receiver.
package acsp_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Rounded to the nearest cycle so the bit-time error stays below half a clock.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 while enabled and pulses on the terminal count.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic system_clock_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_tick_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // The tick must not depend on clear: the FSM derives clear from the tick at the end of a stop bit.
  assign bit_tick_o = enable_i && (count_q == TERMINAL);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = bit_tick_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge system_clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register behind the frame being shifted.
module uart_transmitter #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 9600
) (
  input  logic       system_clock_i,
  input  logic       reset_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       tx_busy_o
);

  import acsp_uart_pkg::*;

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

  uart_tx_state_t state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] holdData_q, holdData_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic       holdFull_q, holdFull_d;
  logic       tx_q, tx_d;
  logic       accept, load, bitTick;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .system_clock_i(system_clock_i),
    .reset_i       (reset_i),
    .clear_i       (load),
    .enable_i      (state_q != IDLE),
    .bit_tick_o    (bitTick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    holdData_d = holdData_q;
    bitIdx_d   = bitIdx_q;
    tx_d       = tx_q;
    accept     = tx_valid_i && !holdFull_q;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (holdFull_q) load = 1'b1;
      end
      START: begin
        if (bitTick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bitTick) begin
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d  = shift_q >> 1;
            bitIdx_d = bitIdx_q + 3'd1;
            tx_d     = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bitTick) begin
          if (holdFull_q) load = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load restarts the frame from the start bit with a fresh bit period.
    if (load) begin
      state_d  = START;
      shift_d  = holdData_q;
      bitIdx_d = 3'd0;
      tx_d     = 1'b0;
    end

    holdFull_d = (holdFull_q && !load) || accept;
    if (accept) holdData_d = tx_data_i;
  end

  always_ff @(posedge system_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      holdData_q <= '0;
      bitIdx_q   <= 3'd0;
      holdFull_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      holdData_q <= holdData_d;
      bitIdx_q   <= bitIdx_d;
      holdFull_q <= holdFull_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_ready_o = !holdFull_q;
  assign tx_o       = tx_q;
  assign tx_busy_o  = (state_q != IDLE) || holdFull_q;

endmodule
